// File: rtl/dl_slp_pkg.sv
// Shared types and constants for the dual-slope ADC sequencer.
package dl_slp_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RST,
      SAMPLE,
      RUNUP,
      RDOWN,
      DONE
   } state_t;

   localparam int SYNC_STAGES = 2;

   function automatic int unsigned cnt_max(input int unsigned w);
      return (32'd1 << w) - 32'd1;
   endfunction

endpackage

// File: rtl/dl_slp_sync.sv
// Multi-flop synchroniser for a single asynchronous level; clears to 0 on reset.
module dl_slp_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] ff;

   always_ff @(posedge clk) begin
      if (rst) ff <= '0;
      else     ff <= {ff[STAGES-2:0], d};
   end

   assign q = ff[STAGES-1];

endmodule

// File: rtl/dl_slp_ctrl.sv
// Dual-slope ADC sequencer: integrator reset, sample, fixed run-up, counted run-down.
//
//  state  | meaning
//  -------+------------------------------------------------------------
//  IDLE   | waiting for conv_req; integrator held in reset
//  RST    | integrator reset for RST_CYCLES cycles
//  SAMPLE | one-cycle start pulse; first run-up cycle (cycle 0)
//  RUNUP  | integrate input for the remaining RUNUP_CYCLES-1 cycles
//  RDOWN  | integrate -VREF, count until comparator trips or saturation
//  DONE   | one-cycle result_valid; integrator back in reset
module dl_slp_ctrl
   import dl_slp_pkg::*;
#(
   parameter int RUNUP_CYCLES = 256,
   parameter int CNT_W        = 10,
   parameter int RST_CYCLES   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             conv_req,
   input  logic             abort,
   input  logic             cmp_out,
   output logic             start,
   output logic             integrator_sel,
   output logic             integrator_rstn,
   output logic             busy,
   output logic [CNT_W-1:0] result,
   output logic             result_valid,
   output logic             overrange,
   output logic             neg_input
);

   localparam int TMR_SPAN = (RUNUP_CYCLES > RST_CYCLES) ? RUNUP_CYCLES : RST_CYCLES;
   localparam int TMR_W    = $clog2(TMR_SPAN + 1);

   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(cnt_max(CNT_W));
   localparam logic [TMR_W-1:0] TMR_RST  = TMR_W'(RST_CYCLES - 1);
   localparam logic [TMR_W-1:0] TMR_RUN  = TMR_W'(RUNUP_CYCLES - 2);

   state_t           state_q, state_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] result_d;
   logic             ov_d, neg_d;
   logic             start_d, sel_d, rstn_d, busy_d, valid_d;
   logic             cmp_s;

   dl_slp_sync #(.STAGES(SYNC_STAGES)) u_cmp_sync (
      .clk (clk),
      .rst (rst),
      .d   (cmp_out),
      .q   (cmp_s)
   );

   always_comb begin
      state_d  = state_q;
      tmr_d    = tmr_q;
      cnt_d    = cnt_q;
      result_d = result;
      ov_d     = overrange;
      neg_d    = neg_input;

      unique case (state_q)
         IDLE: begin
            if (conv_req) begin
               state_d = RST;
               tmr_d   = TMR_RST;
               ov_d    = 1'b0;
               neg_d   = 1'b0;
            end
         end
         RST: begin
            if (tmr_q == '0) state_d = SAMPLE;
            else             tmr_d   = tmr_q - 1'b1;
         end
         SAMPLE: begin
            state_d = RUNUP;
            tmr_d   = TMR_RUN;
         end
         RUNUP: begin
            if (tmr_q == '0) begin
               state_d = RDOWN;
               cnt_d   = '0;
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         RDOWN: begin
            // comparator already tripped on the first cycle means the input was negative
            if (cmp_s) begin
               state_d = DONE;
               if (cnt_q == '0) begin
                  neg_d    = 1'b1;
                  result_d = '0;
               end else begin
                  result_d = cnt_q;
               end
            end else if (cnt_q == CNT_MAX) begin
               state_d  = DONE;
               result_d = CNT_MAX;
               ov_d     = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (abort) begin
         state_d  = IDLE;
         tmr_d    = '0;
         cnt_d    = '0;
         result_d = result;
         ov_d     = 1'b0;
         neg_d    = 1'b0;
      end

      // outputs decoded from the next state so they change with the state register
      start_d = (state_d == SAMPLE);
      sel_d   = (state_d == SAMPLE) || (state_d == RUNUP);
      rstn_d  = (state_d == SAMPLE) || (state_d == RUNUP) || (state_d == RDOWN);
      busy_d  = (state_d != IDLE);
      valid_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= IDLE;
         tmr_q           <= '0;
         cnt_q           <= '0;
         result          <= '0;
         overrange       <= 1'b0;
         neg_input       <= 1'b0;
         start           <= 1'b0;
         integrator_sel  <= 1'b0;
         integrator_rstn <= 1'b0;
         busy            <= 1'b0;
         result_valid    <= 1'b0;
      end else begin
         state_q         <= state_d;
         tmr_q           <= tmr_d;
         cnt_q           <= cnt_d;
         result          <= result_d;
         overrange       <= ov_d;
         neg_input       <= neg_d;
         start           <= start_d;
         integrator_sel  <= sel_d;
         integrator_rstn <= rstn_d;
         busy            <= busy_d;
         result_valid    <= valid_d;
      end
   end

endmodule

// File: tb/tb_dl_slp_ctrl.sv
// Self-checking bench for dl_slp_ctrl: vector table, random conversions, corner sequences, analog model.
module tb_dl_slp_ctrl;

   localparam int RUNUP = 256;
   localparam int RSTC  = 4;
   localparam int MAXV  = 1023;

   logic       clk = 1'b0;
   logic       rst, conv_req, abort, cmp_out;
   logic       start, sel, rstn, busy, result_valid, overrange, neg_input;
   logic [9:0] result;

   logic cmp_drv   = 1'b0;
   logic use_model = 1'b0;
   logic model_cmp = 1'b1;
   real  v_int     = 0.0;
   real  ana_in    = 0.0;

   int checks   = 0;
   int failures = 0;

   int r_res, r_ov, r_neg, r_valid, r_start, r_sel, r_rst, r_busy, r_after, r_done;

   typedef struct {
      int mode;
      int c;
      int exp_res;
      int exp_ov;
      int exp_neg;
   } vec_t;

   vec_t tbl[6];

   assign cmp_out = use_model ? model_cmp : cmp_drv;

   always #5 clk = ~clk;

   dl_slp_ctrl dut (
      .clk             (clk),
      .rst             (rst),
      .conv_req        (conv_req),
      .abort           (abort),
      .cmp_out         (cmp_out),
      .start           (start),
      .integrator_sel  (sel),
      .integrator_rstn (rstn),
      .busy            (busy),
      .result          (result),
      .result_valid    (result_valid),
      .overrange       (overrange),
      .neg_input       (neg_input)
   );

   // ideal integrator: +ana_in per run-up cycle, -VREF (1.0) per run-down cycle
   always @(negedge clk) begin
      if (!rstn)    v_int = 0.0;
      else if (sel) v_int = v_int + ana_in;
      else          v_int = v_int - 1.0;
      model_cmp = (v_int <= 0.0);
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // mode 0: raise cmp_out in run-down cycle c; 1: never raise; 2: high from sample; 3: analog model
   function automatic void ref_conv(input int mode, input int c,
                                    output int res, output int ov, output int neg);
      int trip;
      res = 0; ov = 0; neg = 0;
      if (mode == 2) begin
         neg = 1;
      end else begin
         trip = (mode == 1) ? MAXV + 100 : c + 2;
         if (trip > MAXV) begin
            res = MAXV;
            ov  = 1;
         end else begin
            res = trip;
         end
      end
   endfunction

   task automatic run_conv(input int mode, input int c);
      int idx;
      idx = -1;
      r_res = 0; r_ov = 0; r_neg = 0; r_valid = 0; r_start = 0;
      r_sel = 0; r_rst = 0; r_busy = 0; r_after = 0; r_done = 0;
      @(negedge clk); conv_req = 1'b1;
      @(negedge clk); conv_req = 1'b0;
      for (int n = 0; n < 3000 && r_done == 0; n++) begin
         if (busy) r_busy++;
         if (start) r_start++;
         if (sel) r_sel++;
         if (busy && !rstn && !result_valid) r_rst++;
         if (mode == 2 && sel) cmp_drv = 1'b1;
         if (busy && rstn && !sel) begin
            idx++;
            if (mode == 0 && idx == c) cmp_drv = 1'b1;
         end
         if (result_valid) begin
            r_valid++;
            r_res  = int'(result);
            r_ov   = int'(overrange);
            r_neg  = int'(neg_input);
            r_done = 1;
         end
         if (r_done == 0) @(negedge clk);
      end
      @(negedge clk);
      r_after = int'(busy);
      if (result_valid) r_valid++;
      cmp_drv = 1'b0;
   endtask

   task automatic check_conv(input string name, input int er, input int eo, input int en);
      check({name, ".done"},    r_done,  1);
      check({name, ".result"},  r_res,   er);
      check({name, ".ovr"},     r_ov,    eo);
      check({name, ".neg"},     r_neg,   en);
      check({name, ".valid_n"}, r_valid, 1);
      check({name, ".start_n"}, r_start, 1);
      check({name, ".sel_n"},   r_sel,   RUNUP);
      check({name, ".rst_n"},   r_rst,   RSTC);
      check({name, ".busy_n"},  r_busy,  RSTC + RUNUP + er + 2);
      check({name, ".idle"},    r_after, 0);
   endtask

   initial begin
      int er, eo, en, m, c, d, nv, got;
      tbl[0] = '{0, 99,   101,  0, 0};
      tbl[1] = '{0, 0,    2,    0, 0};
      tbl[2] = '{0, 1021, 1023, 0, 0};
      tbl[3] = '{0, 1022, 1023, 1, 0};
      tbl[4] = '{1, 0,    1023, 1, 0};
      tbl[5] = '{2, 0,    0,    0, 1};

      rst = 1'b1; conv_req = 1'b0; abort = 1'b0;
      repeat (3) @(negedge clk);
      check("rst.start", int'(start), 0);
      check("rst.sel",   int'(sel),   0);
      check("rst.rstn",  int'(rstn),  0);
      check("rst.busy",  int'(busy),  0);
      check("rst.result", int'(result), 0);
      check("rst.valid", int'(result_valid), 0);
      check("rst.ovr",   int'(overrange), 0);
      check("rst.neg",   int'(neg_input), 0);
      rst = 1'b0;

      foreach (tbl[i]) begin
         run_conv(tbl[i].mode, tbl[i].c);
         check_conv($sformatf("tbl%0d", i), tbl[i].exp_res, tbl[i].exp_ov, tbl[i].exp_neg);
      end

      for (int k = 0; k < 8; k++) begin
         m = $urandom_range(0, 7);
         c = $urandom_range(0, 1100);
         m = (m == 0) ? 2 : (m == 1) ? 1 : 0;
         ref_conv(m, c, er, eo, en);
         run_conv(m, c);
         check_conv($sformatf("rnd%0d_m%0d_c%0d", k, m, c), er, eo, en);
      end

      // abort at run-up cycle 50 after a known result
      run_conv(0, 39);
      check("pre_abort.result", r_res, 41);
      nv = 0; got = 0;
      @(negedge clk); conv_req = 1'b1;
      @(negedge clk); conv_req = 1'b0;
      d = 0;
      for (int n = 0; n < 400 && got == 0; n++) begin
         if (result_valid) nv++;
         if (sel) d++;
         if (d == 51) begin
            abort = 1'b1;
            got = 1;
         end else begin
            @(negedge clk);
         end
      end
      check("abort.reached", got, 1);
      @(negedge clk); abort = 1'b0;
      check("abort.busy",   int'(busy), 0);
      check("abort.rstn",   int'(rstn), 0);
      check("abort.sel",    int'(sel),  0);
      check("abort.valid",  int'(result_valid) + nv, 0);
      check("abort.result", int'(result), 41);
      check("abort.ovr",    int'(overrange), 0);
      check("abort.neg",    int'(neg_input), 0);
      repeat (5) @(negedge clk);
      check("abort.stay_idle", int'(busy), 0);

      // synchronous reset in the middle of run-up
      @(negedge clk); conv_req = 1'b1;
      @(negedge clk); conv_req = 1'b0;
      repeat (20) @(negedge clk);
      rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      check("midrst.busy",   int'(busy),   0);
      check("midrst.sel",    int'(sel),    0);
      check("midrst.rstn",   int'(rstn),   0);
      check("midrst.result", int'(result), 0);

      // back-to-back: request held high, comparator high gives short conversions
      cmp_drv = 1'b1;
      @(negedge clk); conv_req = 1'b1;
      for (int k = 0; k < 3; k++) begin
         got = 0;
         for (int n = 0; n < 400 && got == 0; n++) begin
            @(negedge clk);
            if (result_valid) got = 1;
         end
         check($sformatf("b2b%0d.valid_seen", k), got, 1);
         check($sformatf("b2b%0d.neg", k), int'(neg_input), 1);
         @(negedge clk);
         check($sformatf("b2b%0d.idle_gap", k), int'(busy), 0);
         @(negedge clk);
         check($sformatf("b2b%0d.restart", k), int'(busy && !rstn && !start), 1);
      end
      conv_req = 1'b0;
      repeat (300) @(negedge clk);

      // extra requests while busy are dropped
      nv = 0;
      @(negedge clk); conv_req = 1'b1;
      @(negedge clk); conv_req = 1'b0;
      for (int n = 0; n < 700; n++) begin
         if (result_valid) nv++;
         if (busy && (n % 37 == 5)) conv_req = 1'b1;
         @(negedge clk);
         conv_req = 1'b0;
      end
      check("drop.valid_n", nv, 1);
      check("drop.idle", int'(busy), 0);
      cmp_drv = 1'b0;
      repeat (4) @(negedge clk);

      // analog front-end model, VREF = 1.0
      use_model = 1'b1;
      ana_in = 0.5;
      run_conv(3, 0);
      d = r_res - 128; if (d < 0) d = -d;
      check("ana_0p5.done", r_done, 1);
      check("ana_0p5.near128", int'(d <= 3), 1);
      ana_in = 0.25;
      run_conv(3, 0);
      d = r_res - 64; if (d < 0) d = -d;
      check("ana_0p25.near64", int'(d <= 3), 1);
      check("ana_0p25.ovr", r_ov, 0);
      ana_in = -0.2;
      run_conv(3, 0);
      check("ana_neg.neg", r_neg, 1);
      check("ana_neg.result", r_res, 0);
      use_model = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
